// File: rtl/counter_seq_ctrl.sv
// Timer sequencer for a WIDTH-bit up-counter: start/stop/hold control, prescaled
// ticks, programmable terminal count, one-shot or periodic operation.
module counter_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 8
) (
    input  logic               Clk,
    input  logic               RST,
    input  logic               START,
    input  logic               STOP,
    input  logic               HOLD,
    input  logic               MODE,
    input  logic [WIDTH-1:0]   LIMIT,
    input  logic [PRESC_W-1:0] PRESCALE,
    output logic [WIDTH-1:0]   OUT,
    output logic [1:0]         STATE,
    output logic               BUSY,
    output logic               DONE,
    output logic               WRAP
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     limit_q, limit_d;
    logic [PRESC_W-1:0]   pcnt_q, pcnt_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 mode_q, mode_d;
    logic                 done_q, done_d;
    logic                 wrap_q, wrap_d;
    logic                 start_ok;
    logic                 tick;

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            pcnt_q  <= '0;
            presc_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            pcnt_q  <= pcnt_d;
            presc_q <= presc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        limit_d  = limit_q;
        pcnt_d   = pcnt_q;
        presc_d  = presc_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        tick     = 1'b0;
        start_ok = START && (state_q == S_IDLE || state_q == S_DONE);

        if (STOP) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
        end else if (start_ok) begin
            // Configuration is only sampled here; later input changes are ignored.
            limit_d = LIMIT;
            presc_d = PRESCALE;
            mode_d  = MODE;
            cnt_d   = '0;
            pcnt_d  = '0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (HOLD) begin
                        state_d = S_HOLD;
                    end else if (pcnt_q == presc_q) begin
                        pcnt_d = '0;
                        tick   = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!HOLD) state_d = S_RUN;
                end
                default: ;
            endcase
        end

        // Terminal count: periodic wraps to zero, one-shot parks at the limit.
        if (tick) begin
            if (cnt_q != limit_q) begin
                cnt_d = cnt_q + 1'b1;
            end else if (mode_q) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end
    end

    assign OUT   = cnt_q;
    assign STATE = state_q;
    assign BUSY  = (state_q == S_RUN) || (state_q == S_HOLD);
    assign DONE  = done_q;
    assign WRAP  = wrap_q;

    a_pulse_excl : assert property (@(posedge Clk) disable iff (RST) !(done_q && wrap_q));
    a_cnt_bound  : assert property (@(posedge Clk) disable iff (RST) cnt_q <= limit_q);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: a behavioural model predicts the outputs
// after every edge; a monitor compares them on the falling edge.
module tb_counter_seq_ctrl;

    localparam int WIDTH   = 4;
    localparam int PRESC_W = 8;

    logic               Clk = 1'b0;
    logic               RST = 1'b0, START = 1'b0, STOP = 1'b0, HOLD = 1'b0, MODE = 1'b0;
    logic [WIDTH-1:0]   LIMIT = '0;
    logic [PRESC_W-1:0] PRESCALE = '0;
    logic [WIDTH-1:0]   OUT;
    logic [1:0]         STATE;
    logic               BUSY, DONE, WRAP;

    counter_seq_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .Clk(Clk), .RST(RST), .START(START), .STOP(STOP), .HOLD(HOLD), .MODE(MODE),
        .LIMIT(LIMIT), .PRESCALE(PRESCALE), .OUT(OUT), .STATE(STATE), .BUSY(BUSY),
        .DONE(DONE), .WRAP(WRAP)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic [1:0]       st;
        logic             busy;
        logic             done;
        logic             wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: timer phase, count, cycles waited since the last tick.
    localparam int P_IDLE = 0, P_RUN = 1, P_HOLD = 2, P_DONE = 3;
    int m_phase = P_IDLE, m_cnt = 0, m_wait = 0, m_lim = 0, m_pre = 0;
    bit m_per = 0, m_done = 0, m_wrap = 0;

    function automatic void chk(string nm, int act, int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    endfunction

    task automatic model_step();
        m_done = 0;
        m_wrap = 0;
        if (RST) begin
            m_phase = P_IDLE; m_cnt = 0; m_wait = 0; m_lim = 0; m_pre = 0; m_per = 0;
        end else if (STOP) begin
            m_phase = P_IDLE; m_cnt = 0; m_wait = 0;
        end else if (START && (m_phase == P_IDLE || m_phase == P_DONE)) begin
            m_lim = int'(LIMIT); m_pre = int'(PRESCALE); m_per = MODE;
            m_cnt = 0; m_wait = 0; m_phase = P_RUN;
        end else if (m_phase == P_RUN) begin
            if (HOLD) m_phase = P_HOLD;
            else if (m_wait < m_pre) m_wait++;
            else begin
                m_wait = 0;
                if (m_cnt < m_lim) m_cnt++;
                else if (m_per) begin m_cnt = 0; m_wrap = 1; end
                else begin m_phase = P_DONE; m_done = 1; end
            end
        end else if (m_phase == P_HOLD && !HOLD) begin
            m_phase = P_RUN;
        end
    endtask

    // One clock edge: model predicts, scoreboard records, then settle past the edge.
    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            model_step();
            e.out  = WIDTH'(m_cnt);
            e.st   = 2'(m_phase);
            e.busy = (m_phase == P_RUN) || (m_phase == P_HOLD);
            e.done = m_done;
            e.wrap = m_wrap;
            exp_q.push_back(e);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e, g;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {OUT, STATE, BUSY, DONE, WRAP};
                n_chk++;
                if (g === e) n_pass++;
                else $display("FAIL sb_outputs: got OUT=%0d ST=%0d B=%0b D=%0b W=%0b, expected OUT=%0d ST=%0d B=%0b D=%0b W=%0b (t=%0t)",
                              OUT, STATE, BUSY, DONE, WRAP, e.out, e.st, e.busy, e.done, e.wrap, $time);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int n, w1, w2, nwrap, maxout;
        bit got, dseen;

        RST = 1'b1; step(2); RST = 1'b0;
        chk("reset_out", int'(OUT), 0);
        chk("reset_state", int'(STATE), 0);

        // Reset mid-run
        MODE = 0; LIMIT = 9; PRESCALE = 0; START = 1; step(1); START = 0;
        step(4); chk("rst_mid_out4", int'(OUT), 4);
        RST = 1; step(2); RST = 0;
        chk("rst_mid_out", int'(OUT), 0);
        chk("rst_mid_state", int'(STATE), 0);
        chk("rst_mid_flags", int'({BUSY, DONE, WRAP}), 0);
        step(3); chk("rst_after_out", int'(OUT), 0);

        // One-shot LIMIT=5, PRESCALE=0
        MODE = 0; LIMIT = 5; PRESCALE = 0; START = 1; step(1); START = 0;
        for (int i = 1; i <= 5; i++) begin step(1); chk("oneshot_count", int'(OUT), i); end
        step(1);
        chk("oneshot_done", int'(DONE), 1);
        chk("oneshot_state", int'(STATE), 3);
        chk("oneshot_out", int'(OUT), 5);
        chk("oneshot_busy", int'(BUSY), 0);
        step(1); chk("oneshot_done_pulse", int'(DONE), 0);

        // Hold: LIMIT=15, PRESCALE=1, 7 cycles at OUT=6, DONE 8 edges later than unheld
        MODE = 0; LIMIT = 15; PRESCALE = 1; START = 1; step(1); START = 0;
        step(12); chk("hold_pre_out", int'(OUT), 6);
        HOLD = 1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("hold_frozen_out", int'(OUT), 6);
            chk("hold_state", int'(STATE), 2);
        end
        HOLD = 0; n = 19; got = 0;
        while (!got && n < 100) begin step(1); n++; if (DONE) got = 1; end
        chk("hold_done_edge", n, 40);

        // Periodic from DONE: LIMIT=3, PRESCALE=2
        MODE = 1; LIMIT = 3; PRESCALE = 2; START = 1; step(1); START = 0;
        chk("restart_out", int'(OUT), 0);
        chk("restart_state", int'(STATE), 1);
        w1 = -1; w2 = -1; dseen = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (WRAP) begin if (w1 < 0) w1 = i; else if (w2 < 0) w2 = i; end
            if (DONE) dseen = 1;
        end
        chk("periodic_wrap1", w1, 12);
        chk("periodic_wrap2", w2, 24);
        chk("periodic_no_done", int'(dseen), 0);

        // START+STOP together while running
        START = 1; STOP = 1; step(1); START = 0; STOP = 0;
        chk("startstop_state", int'(STATE), 0);
        chk("startstop_out", int'(OUT), 0);

        // START in RUN with a new LIMIT is ignored
        MODE = 0; LIMIT = 4; PRESCALE = 0; START = 1; step(1); START = 0;
        step(2);
        LIMIT = 2; START = 1; step(1); START = 0;
        chk("ignored_start_out", int'(OUT), 3);
        step(1); chk("ignored_start_out4", int'(OUT), 4);
        step(1);
        chk("ignored_start_done", int'(DONE), 1);
        chk("ignored_start_lim", int'(OUT), 4);

        // LIMIT=0 periodic, PRESCALE=3
        MODE = 1; LIMIT = 0; PRESCALE = 3; START = 1; step(1); START = 0;
        nwrap = 0; maxout = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (WRAP) nwrap++;
            if (int'(OUT) > maxout) maxout = int'(OUT);
        end
        chk("lim0_wraps", nwrap, 5);
        chk("lim0_out", maxout, 0);
        STOP = 1; step(1); STOP = 0;

        // Full range one-shot LIMIT=15
        MODE = 0; LIMIT = 15; PRESCALE = 0; START = 1; step(1); START = 0;
        step(15); chk("full_out15", int'(OUT), 15);
        step(1);
        chk("full_done", int'(DONE), 1);
        chk("full_hold15", int'(OUT), 15);
        step(1); chk("full_no_wrap", int'(OUT), 15);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            RST   = ($urandom_range(0, 149) == 0);
            STOP  = ($urandom_range(0, 39) == 0);
            START = ($urandom_range(0, 5) == 0);
            HOLD  = ($urandom_range(0, 4) == 0);
            MODE  = 1'($urandom_range(0, 1));
            LIMIT = WIDTH'($urandom_range(0, 15));
            PRESCALE = ($urandom_range(0, 15) == 0) ? PRESC_W'($urandom_range(0, 40))
                                                    : PRESC_W'($urandom_range(0, 2));
            step(1);
        end
        RST = 0; STOP = 0; START = 0; HOLD = 0;
        step(2);
        @(negedge Clk); @(negedge Clk);
        chk("scoreboard_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer for the 4-bit up-counter datapath. It owns the count register and drives it through start, stop, hold and terminal-count events, with a programmable prescaler, a programmable limit, and a one-shot or periodic mode. It sits between the command/control logic and any consumer of the count value OUT. It replaces free-running counting with a controlled timer.

Parameters:
WIDTH, 4, count width (OUT, LIMIT)
PRESC_W, 8, prescaler width (PRESCALE)

Ports:
Clk  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
START  input  1  start request, sampled each edge
STOP  input  1  abort request, sampled each edge
HOLD  input  1  level; freezes the run while high
MODE  input  1  0 = one-shot, 1 = periodic; latched at start
LIMIT  input  WIDTH  terminal count; latched at start
PRESCALE  input  PRESC_W  a tick occurs every PRESCALE+1 cycles; latched at start
OUT  output  WIDTH  count value (registered)
STATE  output  2  00 IDLE, 01 RUN, 10 HOLD, 11 DONE
BUSY  output  1  high in RUN or HOLD; decoded from the state register
DONE  output  1  one-cycle pulse on entry to DONE
WRAP  output  1  one-cycle pulse on periodic wrap

Behaviour:
- One clock (Clk); reset is synchronous and active-high (RST). All state changes occur on the rising edge of Clk.
- Reset values: OUT=0, STATE=IDLE, BUSY=0, DONE=0, WRAP=0. The prescaler counter and the shadow registers (limit_q, presc_q, mode_q) are also cleared to 0.
- Priority per edge, highest first: RST > STOP > START > HOLD > tick.
- STOP, from any state: next state IDLE, OUT←0, prescaler counter←0, no DONE or WRAP pulse.
- START, only from IDLE or DONE:
  - latch LIMIT, PRESCALE and MODE into the shadow registers;
  - OUT←0, prescaler counter←0, next state RUN.
  - START in RUN or HOLD is ignored.
- Input changes on LIMIT, PRESCALE and MODE outside a start edge have no effect.
- RUN:
  - HOLD=1 → next state HOLD. The count and prescaler counter do not change on that edge.
  - Otherwise, if prescaler counter == presc_q: tick, and the prescaler counter←0. If not, the prescaler counter increments.
- Tick handling:
  - OUT != limit_q → OUT←OUT+1.
  - OUT == limit_q and mode_q=1 → OUT←0, WRAP=1 for one cycle, stay in RUN.
  - OUT == limit_q and mode_q=0 → next state DONE, DONE=1 for one cycle, OUT holds limit_q.
- HOLD state: OUT and the prescaler counter are frozen. HOLD=0 → return to RUN on the next edge, and the prescaler resumes from its frozen value. STOP is still honoured here.
- DONE state: BUSY=0, OUT holds limit_q. The block stays in DONE until START or STOP.
- Latency: START sampled at edge k → RUN with OUT=0 after edge k. The first increment happens at edge k+PRESCALE+1, and each later step follows every PRESCALE+1 edges.
- Boundaries:
  - PRESCALE=0 → a tick on every RUN cycle.
  - LIMIT=0 → one-shot enters DONE on the first tick. Periodic pulses WRAP on every tick with OUT held at 0.
  - LIMIT=2^WIDTH−1 → full range with no overflow past the limit.
  - OUT never exceeds limit_q.
- Reset during RUN or HOLD aborts immediately to the reset values.
- DONE and WRAP are never high in the same cycle.

Test Plan:
- Reset mid-run: LIMIT=9, PRESCALE=0, START, then RST high for 2 cycles at OUT=4 → OUT=0, STATE=00, BUSY=0, DONE=0, WRAP=0. Later count edges cause no change.
- One-shot: MODE=0, LIMIT=5, PRESCALE=0, START at edge k → OUT=1..5 at edges k+1..k+5. At edge k+6, DONE pulses for 1 cycle, STATE=11, OUT stays 5, BUSY=0.
- Periodic with prescale: MODE=1, LIMIT=3, PRESCALE=2 → OUT steps every 3 cycles in the sequence 0,1,2,3,0. WRAP pulses once every 12 cycles, and DONE stays 0.
- Hold: one-shot, LIMIT=15, PRESCALE=1, HOLD high for 7 cycles at OUT=6 → STATE=10, OUT frozen at 6. After release, the timing continues exactly where it stopped, and DONE arrives 7+1 cycles later than in an unheld run.
- Command conflicts:
  - START and STOP in the same cycle during RUN → IDLE, OUT=0.
  - START while in RUN with LIMIT changed to 2 → ignored; the original limit is still used.
  - START from DONE → restarts with OUT=0.
- Edge limits: LIMIT=0, MODE=1, PRESCALE=3 → WRAP every 4 cycles, OUT=0 throughout. LIMIT=15, MODE=0, PRESCALE=0 → reaches 15, then DONE; no wrap to 0.
